// File: rtl/p_to_s_if.sv
// Parallel word port and serial bit port of the parallel-to-serial front end.
// slave = the serializer itself, master = whatever drives words in and bits out.
interface p_to_s_if #(
   parameter int WIDTH = 6
);
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_ready;
   logic             valid_a;
   logic             data_a;
   logic             ready_a;

   modport slave (
      input  s_valid,
      input  s_data,
      input  ready_a,
      output s_ready,
      output valid_a,
      output data_a
   );

   modport master (
      output s_valid,
      output s_data,
      output ready_a,
      input  s_ready,
      input  valid_a,
      input  data_a
   );
endinterface

// File: rtl/p_to_s.sv
// Parallel-to-serial front end: words are buffered in a DEPTH-entry FIFO and
// emitted LSB-first, one bit per accepted beat, on the valid/ready serial port.
module p_to_s #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   p_to_s_if.slave   bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bit_cnt;
   logic             r_valid_a;
   logic             r_data_a;

   state_t           w_state_next;
   logic [WIDTH-1:0] w_shreg_next;
   logic [BW-1:0]    w_bit_cnt_next;
   logic             w_valid_next;
   logic             w_data_next;
   logic             w_pop;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH-1:0] w_head;
   logic [BW-1:0]    w_bit_inc;

   assign w_full      = (r_count == FULL_CNT);
   assign w_empty     = (r_count == '0);
   assign w_push      = bus.s_valid && !w_full;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_bit_inc   = r_bit_cnt + BW'(1);

   assign bus.s_ready = !w_full;
   assign bus.valid_a = r_valid_a;
   assign bus.data_a  = r_data_a;

   // FIFO storage carries no reset: emptiness is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= bus.s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_valid_a <= 1'b0;
         r_data_a  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shreg   <= w_shreg_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_valid_a <= w_valid_next;
         r_data_a  <= w_data_next;
      end
   end

   // A word is loaded straight from the FIFO head so the next word can follow
   // the last bit of the current one with no idle beat in between.
   always_comb begin
      w_state_next   = r_state;
      w_shreg_next   = r_shreg;
      w_bit_cnt_next = r_bit_cnt;
      w_valid_next   = r_valid_a;
      w_data_next    = r_data_a;
      w_pop          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop          = 1'b1;
               w_shreg_next   = w_head;
               w_data_next    = w_head[0];
               w_valid_next   = 1'b1;
               w_bit_cnt_next = '0;
               w_state_next   = ST_SHIFT;
            end else begin
               w_valid_next   = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (bus.ready_a) begin
               if (r_bit_cnt != LAST_BIT) begin
                  w_bit_cnt_next = w_bit_inc;
                  w_data_next    = r_shreg[w_bit_inc];
               end else if (!w_empty) begin
                  w_pop          = 1'b1;
                  w_shreg_next   = w_head;
                  w_data_next    = w_head[0];
                  w_valid_next   = 1'b1;
                  w_bit_cnt_next = '0;
               end else begin
                  w_valid_next   = 1'b0;
                  w_state_next   = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_valid_next = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_p_to_s.sv
// Bench for p_to_s: a word-level model predicts valid_a/data_a/s_ready every
// cycle, and directed tests pin that model with hand-computed literals.
module tb_p_to_s;
   localparam int W = 6;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n;

   p_to_s_if #(.WIDTH(W)) bus ();

   p_to_s #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: per accepted word, the edge it was pushed and its bits in send order.
   int           m_push_edge[$];
   bit           m_bits[$];
   int           m_beat_in_word = 0;
   logic         m_exp_valid;
   int           m_fifo_cnt;
   logic [W-1:0] m_tmp;

   // Receiver: reassembles accepted beats into words, like the collector would.
   logic [W-1:0] rx_shift = '0;
   int           rx_nbits = 0;
   int           rx_cur_first = 0;
   logic [W-1:0] rx_words[$];
   int           rx_first[$];
   int           rx_last[$];
   int           beats_total = 0;
   logic [W-1:0] sent[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_push_edge.delete();
         m_bits.delete();
         m_beat_in_word = 0;
         rx_nbits       = 0;
      end else begin
         // A word pushed at edge N can be on the wire at the earliest after N+1.
         m_exp_valid = (m_push_edge.size() > 0) && (m_push_edge[0] <= cyc - 1);
         m_fifo_cnt  = m_push_edge.size() - (m_exp_valid ? 1 : 0);
         check("valid_a", 32'(bus.valid_a), 32'(m_exp_valid));
         check("s_ready", 32'(bus.s_ready), 32'(m_fifo_cnt != D));
         if (m_exp_valid && m_bits.size() > 0)
            check("data_a", 32'(bus.data_a), 32'(m_bits[0]));

         if (bus.s_valid && bus.s_ready) begin
            m_push_edge.push_back(cyc + 1);
            m_tmp = bus.s_data;
            for (int i = 0; i < W; i++) begin
               m_bits.push_back(m_tmp[0]);
               m_tmp = m_tmp >> 1;
            end
         end

         if (bus.valid_a && bus.ready_a) begin
            if (rx_nbits == 0)
               rx_cur_first = cyc + 1;
            rx_shift = {bus.data_a, rx_shift[W-1:1]};
            rx_nbits++;
            if (rx_nbits == W) begin
               rx_words.push_back(rx_shift);
               rx_first.push_back(rx_cur_first);
               rx_last.push_back(cyc + 1);
               rx_nbits = 0;
            end
            beats_total++;
            if (m_bits.size() > 0)
               void'(m_bits.pop_front());
            m_beat_in_word++;
            if (m_beat_in_word == W) begin
               m_beat_in_word = 0;
               if (m_push_edge.size() > 0)
                  void'(m_push_edge.pop_front());
            end
         end
      end
   end

   logic rand_ready = 1'b0;
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready)
         bus.ready_a = 1'($urandom_range(0, 1));
   end

   task automatic push(input logic [W-1:0] w, output int edge_n);
      int t = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      while (!bus.s_ready && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("push_accept", 32'(bus.s_ready), 32'(1));
      @(posedge clk);
      #1;
      edge_n      = cyc;
      bus.s_valid = 1'b0;
      sent.push_back(w);
   endtask

   task automatic wait_words(input int n, input int limit);
      int t = 0;
      while (rx_words.size() < n && t < limit) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("wait_words", 32'(rx_words.size()), 32'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e1, e2, n0, b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.ready_a = 1'b0;
      rst_n       = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_a", 32'(bus.valid_a), 32'(0));
      check("rst_data_a",  32'(bus.data_a),  32'(0));
      check("rst_s_ready", 32'(bus.s_ready), 32'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_s_ready", 32'(bus.s_ready), 32'(1));

      // Single word 6'b101101
      bus.ready_a = 1'b1;
      n0 = rx_words.size();
      push(6'b101101, e);
      check("t1_latency_low", 32'(bus.valid_a), 32'(0));
      @(posedge clk);
      #1;
      check("t1_valid_first", 32'(bus.valid_a), 32'(1));
      check("t1_bit0", 32'(bus.data_a), 32'(1));
      wait_words(n0 + 1, 50);
      check("t1_word", 32'(rx_words[n0]), 32'(6'b101101));
      check("t1_first_beat", 32'(rx_first[n0]), 32'(e + 2));
      check("t1_span", 32'(rx_last[n0] - rx_first[n0]), 32'(5));
      check("t1_idle_after", 32'(bus.valid_a), 32'(0));

      // Back-to-back 6'h15, 6'h2A
      repeat (2) @(posedge clk);
      #1;
      n0 = rx_words.size();
      push(6'h15, e1);
      push(6'h2A, e2);
      wait_words(n0 + 2, 50);
      check("t2_bits", 32'({rx_words[n0+1], rx_words[n0]}), 32'(12'hA95));
      check("t2_no_gap", 32'(rx_first[n0+1]), 32'(rx_last[n0] + 1));
      check("t2_span", 32'(rx_last[n0+1] - rx_first[n0]), 32'(11));

      // Backpressure after bit 2 of 6'h3C
      repeat (2) @(posedge clk);
      #1;
      n0 = rx_words.size();
      b0 = beats_total;
      push(6'h3C, e);
      repeat (4) @(posedge clk);
      #1;
      bus.ready_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t3_hold_valid", 32'(bus.valid_a), 32'(1));
         check("t3_hold_bit3", 32'(bus.data_a), 32'(1));
         @(posedge clk);
         #1;
      end
      bus.ready_a = 1'b1;
      wait_words(n0 + 1, 50);
      check("t3_word", 32'(rx_words[n0]), 32'(6'h3C));
      check("t3_beats", 32'(beats_total - b0), 32'(6));
      check("t3_span", 32'(rx_last[n0] - rx_first[n0]), 32'(8));

      // Full: 5 words fit (1 in shreg + 4 in FIFO), the 6th is refused
      repeat (2) @(posedge clk);
      #1;
      bus.ready_a = 1'b0;
      n0 = rx_words.size();
      for (int k = 1; k <= 5; k++)
         push(W'(k), e);
      check("t4_full_after_5", 32'(bus.s_ready), 32'(0));
      bus.s_valid = 1'b1;
      bus.s_data  = 6'h06;
      @(posedge clk);
      #1;
      check("t4_refuse_6th", 32'(bus.s_ready), 32'(0));
      bus.s_valid = 1'b0;
      bus.ready_a = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("t4_still_full", 32'(bus.s_ready), 32'(0));
      @(posedge clk);
      #1;
      check("t4_ready_after_pop", 32'(bus.s_ready), 32'(1));
      wait_words(n0 + 5, 100);
      for (int k = 0; k < 5; k++)
         check("t4_order", 32'(rx_words[n0+k]), 32'(k + 1));
      repeat (10) @(posedge clk);
      #1;
      check("t4_no_6th", 32'(rx_words.size()), 32'(n0 + 5));

      // Reset during bit 3 of 6'h0F with two words buffered
      n0 = rx_words.size();
      push(6'h0F, e);
      push(6'h21, e1);
      push(6'h12, e2);
      repeat (2) @(posedge clk);
      #1;
      check("t5_bit3_before_rst", 32'(bus.data_a), 32'(1));
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.valid_a), 32'(0));
      check("t5_rst_data", 32'(bus.data_a), 32'(0));
      check("t5_rst_s_ready", 32'(bus.s_ready), 32'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("t5_quiet_valid", 32'(bus.valid_a), 32'(0));
      check("t5_no_words", 32'(rx_words.size()), 32'(n0));

      // Loopback: 50 random words under random backpressure
      sent.delete();
      n0 = rx_words.size();
      rand_ready = 1'b1;
      for (int k = 0; k < 50; k++) begin
         push(W'($urandom_range(0, 63)), e);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_words(n0 + 50, 3000);
      rand_ready  = 1'b0;
      bus.ready_a = 1'b1;
      for (int k = 0; k < 50; k++)
         check("t6_loopback", 32'(rx_words[n0+k]), 32'(sent[k]));
      repeat (20) @(posedge clk);
      #1;
      check("t6_word_count", 32'(rx_words.size()), 32'(n0 + 50));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/p_to_s.md
# p_to_s

Parallel-to-serial front end for the 6-bit serial link. It accepts 6-bit words on a valid/ready parallel port and buffers them in a small FIFO. It then emits each word LSB-first as a bit stream on the (valid_a, data_a, ready_a) serial port, which feeds the serial-to-parallel collector directly. Bit order, word width and handshake match that collector, so a word sent here reappears unchanged on its 6-bit output.

## Interface
- WIDTH, 6, bits per word; must equal the collector's word width.
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  parallel word present.
- s_data  in  WIDTH  parallel word.
- s_ready  out  1  FIFO can accept a word. Combinational: count != DEPTH.
- valid_a  out  1  serial bit valid (registered).
- data_a  out  1  serial bit (registered).
- ready_a  in  1  downstream accepts the bit.

## Operation
- Push happens on s_valid && s_ready: s_data is written at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- Pop happens when the serializer loads a word: rd_ptr+1 (wraps), count-1.
- Push and pop in the same cycle leave count unchanged. Push is never attempted when full (s_ready=0).
- count width is clog2(DEPTH)+1. Full is count==DEPTH; empty is count==0.
- Serializer FSM, IDLE and SHIFT:
  - IDLE with FIFO non-empty: load shreg from the head, pop, set data_a=head[0], valid_a=1, bit_cnt=0, go to SHIFT.
  - IDLE with FIFO empty: valid_a=0 and data_a holds its last value.
  - SHIFT with ready_a=0: hold valid_a, data_a, bit_cnt and shreg. Bits are never dropped or advanced.
  - SHIFT with ready_a=1 and bit_cnt<WIDTH-1: bit_cnt+1, data_a=shreg[bit_cnt+1].
  - SHIFT with ready_a=1 and bit_cnt==WIDTH-1, FIFO non-empty: load the next word back-to-back (pop, bit_cnt=0, data_a=next[0], valid_a stays 1) and stay in SHIFT.
  - SHIFT with ready_a=1 and bit_cnt==WIDTH-1, FIFO empty: valid_a=0, go to IDLE.
- valid_a is high for exactly WIDTH accepted beats per word. Words never interleave or truncate.
- Total capacity is DEPTH words in the FIFO plus 1 word in shreg.

## Timing
- Reset values: valid_a=0, data_a=0, FSM=IDLE, bit_cnt=0, count=0, pointers=0, shreg=0. s_ready=1 during and after reset.
- Latency into an empty, idle block: a word pushed at edge N gives valid_a=1 with bit0 after edge N+1.
- Throughput with ready_a held high: 1 bit/cycle, no idle cycle between consecutive buffered words.
- A new word is presented no earlier than the cycle after the last bit is accepted.
- s_ready deasserts in the cycle after the push that makes count==DEPTH. It reasserts in the cycle after a pop.
- Reset asserted mid-word: the partial word is discarded, FIFO contents are lost and outputs go to reset values immediately. After release the block is IDLE and empty. No partial bits are emitted.
- ready_a is sampled only while valid_a=1 (in SHIFT). It is ignored in IDLE.

## Test plan
- Single word: push 6'b101101 with ready_a=1. Required: valid_a high for 6 cycles starting 1 cycle after the push, data_a = 1,0,1,1,0,1, then valid_a=0.
- Back-to-back: push 6'h15 then 6'h2A in consecutive cycles with ready_a=1. Required: 12 contiguous valid_a cycles, data_a = 1,0,1,0,1,0,0,1,0,1,0,1, no gap.
- Backpressure mid-word: push 6'h3C and drop ready_a for 3 cycles after bit 2 is accepted. Required: data_a holds bit 3 (=1) with valid_a=1 for those 3 cycles, then the remaining bits resume. Total accepted beats = 6.
- Full: hold ready_a=0 and push 6 words 6'h01..6'h06. Required: the first 5 are accepted (1 in shreg, 4 in FIFO) and s_ready=0 from the cycle after the 5th push. Then set ready_a=1: exactly 6'h01..6'h05 are emitted in order and s_ready returns to 1 one cycle after the first pop.
- Reset mid-operation: pull rst_n low during bit 3 of a word while 2 words are buffered. Required: valid_a=0 and data_a=0 immediately. After release there is no serial activity until a new push.
- Loopback: connect to the serial-to-parallel collector and push 50 random words. Required: the collector outputs the same 50 values in order, one valid pulse each.
